hilo_muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer that owns the HI/LO architectural registers of the 5-stage pipeline. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and iterates the arithmetic over 32 cycles. Holds the pipeline with `stall_ex` while any HI/LO instruction would conflict with an operation in flight. Drives the HI/LO values that MFHI/MFLO read in EX; forwarding of those values to later stages stays in the existing bypass logic.

---
 rtl/hilo_muldiv_ctrl_pkg.sv | 28 ++
 rtl/hilo_muldiv_ctrl_step.sv | 41 ++++
 rtl/hilo_muldiv_ctrl.sv | 129 ++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
package hilo_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;
    localparam int unsigned ITERS         = WIDTH_DEFAULT;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic is_hilo_funct(input logic [5:0] fn);
        return (fn == FN_MFHI) || (fn == FN_MTHI) || (fn == FN_MFLO) ||
               (fn == FN_MTLO) || (fn == FN_MULT) || (fn == FN_MULTU) ||
               (fn == FN_DIV)  || (fn == FN_DIVU);
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_step.sv
// One iteration of shift-add multiply or restoring divide.
// Multiply: acc = {partial product, remaining multiplier bits}.
// Divide:   acc = {partial remainder, remaining dividend / quotient bits};
//           the new quotient bit is returned separately, acc_next[0] is 0.
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_next,
    output logic                 q_bit
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // Single-cycle datapath for the selected mode
    always_comb begin
        acc_next = '0;
        q_bit    = 1'b0;
        sum      = '0;
        shifted  = '0;
        diff     = '0;
        if (is_div) begin
            shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
            diff    = shifted[WIDTH-1:0] - operand;
            if (shifted >= {1'b0, operand}) begin
                q_bit    = 1'b1;
                acc_next = {diff, acc[WIDTH-2:0], 1'b0};
            end else begin
                acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner: sequences MULT/DIV over WIDTH cycles and stalls EX on conflicts.
module hilo_muldiv_ctrl
    import hilo_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid_ex,
    input  logic [5:0]       func_ex,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             stall_ex,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t                 state, state_next;
    logic [CW-1:0]          count;
    logic [2*WIDTH-1:0]     acc, step_acc;
    logic                   step_q;
    logic [WIDTH-1:0]       operand, rs_latched;
    logic                   neg_q, neg_r, is_div, div_zero;
    logic [WIDTH-1:0]       hi, lo;

    logic                   hilo_op, accept, start, signed_op, last_iter;
    logic [WIDTH-1:0]       rs_mag, rt_mag;
    logic [2*WIDTH-1:0]     product;
    logic [WIDTH-1:0]       quot, rem;

    assign hilo_op   = op_valid_ex & is_hilo_funct(func_ex);
    assign busy      = (state != IDLE);
    assign stall_ex  = hilo_op & busy;
    assign accept    = hilo_op & ~busy;
    assign start     = accept & (func_ex[5:2] == 4'b0110);
    assign signed_op = (func_ex == FN_MULT) || (func_ex == FN_DIV);
    assign rs_mag    = (signed_op && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    assign rt_mag    = (signed_op && rt_data[WIDTH-1]) ? -rt_data : rt_data;
    assign last_iter = (count == CW'(WIDTH - 1));
    assign hi_out    = hi;
    assign lo_out    = lo;

    // Sign correction applied in FIX
    assign product = neg_q ? -acc : acc;
    assign quot    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem     = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div),
        .acc      (acc),
        .operand  (operand),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (last_iter) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Iteration counter, operand/sign latches and accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            acc        <= '0;
            operand    <= '0;
            rs_latched <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            is_div     <= 1'b0;
            div_zero   <= 1'b0;
        end else if (start) begin
            count      <= '0;
            is_div     <= func_ex[1];
            acc        <= {{WIDTH{1'b0}}, (func_ex[1] ? rs_mag : rt_mag)};
            operand    <= func_ex[1] ? rt_mag : rs_mag;
            rs_latched <= rs_data;
            neg_q      <= signed_op & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            neg_r      <= signed_op & rs_data[WIDTH-1];
            div_zero   <= (rt_data == '0);
        end else if (state == CALC) begin
            count <= count + 1'b1;
            acc   <= step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
        end else begin
            count <= '0;
        end
    end

    // HI/LO architectural registers and completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == FIX);
            if (accept && func_ex == FN_MTHI) hi <= rs_data;
            if (accept && func_ex == FN_MTLO) lo <= rs_data;
            if (state == FIX) begin
                if (!is_div) begin
                    {hi, lo} <= product;
                end else if (div_zero) begin
                    hi <= rs_latched;
                    lo <= '1;
                end else begin
                    hi <= rem;
                    lo <= quot;
                end
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl.
module tb_hilo_muldiv_ctrl;
    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid_ex = 1'b0;
    logic [5:0]  func_ex = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic [31:0] hi_out, lo_out;
    logic        busy, stall_ex, done;

    int compared = 0;
    int mismatched = 0;

    hilo_muldiv_ctrl #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_valid_ex (op_valid_ex),
        .func_ex     (func_ex),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .busy        (busy),
        .stall_ex    (stall_ex),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  func;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic run_op(input vec_t v);
        int n;
        @(negedge clk);
        op_valid_ex = 1'b1; func_ex = v.func; rs_data = v.rs; rt_data = v.rt;
        @(posedge clk);
        @(negedge clk);
        op_valid_ex = 1'b0; func_ex = '0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({v.name, " busy_cycles"}, n, 33);
        check({v.name, " done"}, {31'b0, done}, 1);
        check({v.name, " hi"}, hi_out, v.hi);
        check({v.name, " lo"}, lo_out, v.lo);
        @(negedge clk);
        check({v.name, " done_clear"}, {31'b0, done}, 0);
    endtask

    initial begin
        int n;
        vecs[0] = '{"mult_neg3x5",  FN_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1] = '{"multu_max",    FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{"div_neg7by2",  FN_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{"divu_by0",     FN_DIVU,  32'd100,       32'd0,        32'd100,       32'hFFFF_FFFF};
        vecs[4] = '{"div_minbyneg1",FN_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000};
        vecs[5] = '{"mult_7x9",     FN_MULT,  32'd7,         32'd9,        32'h0,         32'd63};
        vecs[6] = '{"mult_negxneg", FN_MULT,  32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0,        32'd6};
        vecs[7] = '{"div_7byneg2",  FN_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD};

        // reset state
        #1;
        check("rst_hi", hi_out, 0);
        check("rst_lo", lo_out, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_stall", {31'b0, stall_ex}, 0);
        @(negedge clk); rst_n = 1'b1;

        foreach (vecs[i]) run_op(vecs[i]);

        // MFLO stalls behind DIVU 100/7, then sees the quotient
        @(negedge clk);
        op_valid_ex = 1'b1; func_ex = FN_DIVU; rs_data = 32'd100; rt_data = 32'd7;
        @(posedge clk);
        @(negedge clk);
        func_ex = FN_MFLO;
        n = 0;
        while (stall_ex && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("mflo_stall_cycles", n, 33);
        check("mflo_lo", lo_out, 14);
        check("mflo_hi", hi_out, 2);
        check("mflo_done", {31'b0, done}, 1);

        // MTLO then MFLO the next cycle
        @(negedge clk);
        func_ex = FN_MTLO; rs_data = 32'h1234;
        @(negedge clk);
        func_ex = FN_MFLO; rs_data = '0;
        check("mtlo_nostall", {31'b0, stall_ex}, 0);
        check("mtlo_lo", lo_out, 32'h1234);
        @(negedge clk);
        func_ex = FN_MTHI; rs_data = 32'hCAFE_0001;
        @(negedge clk);
        func_ex = FN_MFHI;
        check("mthi_hi", hi_out, 32'hCAFE_0001);
        op_valid_ex = 1'b0;

        // reset in the middle of a MULT
        @(negedge clk);
        op_valid_ex = 1'b1; func_ex = FN_MULT; rs_data = 32'd7; rt_data = 32'd9;
        @(posedge clk);
        @(negedge clk);
        op_valid_ex = 1'b0;
        repeat (9) @(negedge clk);
        check("midcalc_busy", {31'b0, busy}, 1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, busy}, 0);
        check("arst_hi", hi_out, 0);
        check("arst_lo", lo_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        op_valid_ex = 1'b1; func_ex = FN_MFHI;
        #1;
        check("arst_mfhi_nostall", {31'b0, stall_ex}, 0);
        @(negedge clk);
        op_valid_ex = 1'b0;
        check("arst_still_idle", {31'b0, busy}, 0);
        check("arst_no_done", {31'b0, done}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
